// File: rtl/uart_frame_tx_pkg.sv
// Shared types and constants for the UART frame transmitter and its bit timer.
package uart_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load latches the period, bit_done flags the last cycle
// of each bit while running. Written to be shared with a future receiver.
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             bit_done
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] period_q;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      count    <= '0;
      period_q <= '0;
    end else if (load) begin
      period_q <= period;
      count    <= period - ONE;
    end else if (run) begin
      if (count == '0) count <= period_q - ONE;
      else             count <= count - ONE;
    end
  end

  assign bit_done = run & (count == '0);

endmodule

// File: rtl/uart_frame_tx.sv
// UART 8N1 transmitter with a one-byte holding buffer for gapless back-to-back frames.
// Define UART_FRAME_TX_PARITY_EN to add a parity bit (parity_odd_i selects odd parity).
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte and enable_i
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | parity bit (only with UART_FRAME_TX_PARITY_EN)
// STOP   | stop bit(s), then IDLE or straight into START
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1,
  parameter int MIN_DIV   = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] clkdiv_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
`ifdef UART_FRAME_TX_PARITY_EN
  input  logic             parity_odd_i,
`endif
  output logic             ready_o,
  output logic             tx_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

  tx_state_t        state;
  logic [7:0]       buf_data;
  logic             buf_full;
  logic [7:0]       shift;
  logic [2:0]       idx;
  logic             tx;
  logic             rst_done;
  logic [DIV_W-1:0] div_eff;
  logic             bit_done;
  logic             last_stop;
  logic             start_now;
  logic             run;
  logic             handshake;
`ifdef UART_FRAME_TX_PARITY_EN
  logic             par_bit;
`endif

  assign div_eff   = (clkdiv_i < MIN_DIV_V) ? MIN_DIV_V : clkdiv_i;
  assign last_stop = (idx == 3'(STOP_BITS - 1));
  assign run       = (state != IDLE);
  assign start_now = buf_full & enable_i &
                     ((state == IDLE) | ((state == STOP) & bit_done & last_stop));
  assign ready_o   = enable_i & ~buf_full & rst_done;
  assign handshake = valid_i & ready_o;
  assign busy_o    = (state != IDLE) | buf_full;
  assign tx_o      = tx;

  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clock    (clock),
    .resetb   (resetb),
    .load     (start_now),
    .run      (run),
    .period   (div_eff),
    .bit_done (bit_done)
  );

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      buf_data <= '0;
      buf_full <= 1'b0;
      shift    <= '0;
      idx      <= '0;
      rst_done <= 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      rst_done <= 1'b1;
      // start_now and handshake are exclusive: ready_o is low while buf_full
      if (handshake) begin
        buf_data <= data_i;
        buf_full <= 1'b1;
      end
      if (start_now) begin
        state    <= START;
        tx       <= 1'b0;
        shift    <= buf_data;
        buf_full <= 1'b0;
        idx      <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
        par_bit  <= (^buf_data) ^ parity_odd_i;
`endif
      end else begin
        case (state)
          IDLE: tx <= IDLE_LEVEL;
          START:
            if (bit_done) begin
              state <= DATA;
              tx    <= shift[0];
              idx   <= '0;
            end
          DATA:
            if (bit_done) begin
              if (idx == 3'(DATA_BITS - 1)) begin
                idx <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
                state <= PARITY;
                tx    <= par_bit;
`else
                state <= STOP;
                tx    <= IDLE_LEVEL;
`endif
              end else begin
                idx   <= idx + 3'd1;
                shift <= shift >> 1;
                tx    <= shift[1];
              end
            end
`ifdef UART_FRAME_TX_PARITY_EN
          PARITY:
            if (bit_done) begin
              state <= STOP;
              tx    <= IDLE_LEVEL;
              idx   <= '0;
            end
`endif
          STOP:
            if (bit_done) begin
              if (last_stop) state <= IDLE;
              else           idx   <= idx + 3'd1;
            end
          default: begin
            state <= IDLE;
            tx    <= IDLE_LEVEL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx; also covers the parity build when
// UART_FRAME_TX_PARITY_EN is defined.
module tb_uart_frame_tx;

`ifdef UART_FRAME_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        enable_i = 1'b1;
  logic [15:0] clkdiv_i = 16'd4;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        parity_odd = 1'b0;
  logic        ready_o, tx_o, busy_o;

  int n_checks = 0;
  int n_fails  = 0;

  uart_frame_tx dut (
    .clock        (clock),
    .resetb       (resetb),
    .enable_i     (enable_i),
    .clkdiv_i     (clkdiv_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
`ifdef UART_FRAME_TX_PARITY_EN
    .parity_odd_i (parity_odd),
`endif
    .ready_o      (ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k, input logic odd);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // Offer one byte; returns 1ns after the handshake edge.
  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clock);
    while (!ready_o && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (!ready_o) check("ready_timeout", {31'd0, ready_o}, 32'd1);
    data_i  = b;
    valid_i = 1'b1;
    @(posedge clock);
    #1 valid_i = 1'b0;
  endtask

  // Checks every cycle of a frame; the next negedge must be its first cycle.
  task automatic check_frame(input string tag, input logic [7:0] b, input int div);
    for (int k = 0; k < NBITS; k++)
      for (int c = 0; c < div; c++) begin
        @(negedge clock);
        check(tag, {31'd0, tx_o}, {31'd0, frame_bit(b, k, parity_odd)});
      end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    resetb = 1'b1;
    @(negedge clock);
    check("post_rst_ready", {31'd0, ready_o}, 32'd1);

    // single byte
    send(8'hA5);
    @(negedge clock);
    check("a5_latency", {31'd0, tx_o}, 32'd1);
    check("a5_busy", {31'd0, busy_o}, 32'd1);
    check_frame("a5_frame", 8'hA5, 4);
    @(negedge clock);
    check("a5_busy_end", {31'd0, busy_o}, 32'd0);
    check("a5_idle", {31'd0, tx_o}, 32'd1);

`ifdef UART_FRAME_TX_PARITY_EN
    parity_odd = 1'b1;
    send(8'hA5);
    @(negedge clock);
    check_frame("a5_odd_frame", 8'hA5, 4);
    @(negedge clock);
    check("a5_odd_busy_end", {31'd0, busy_o}, 32'd0);
    parity_odd = 1'b0;
`endif

    // back-to-back with valid held high
    @(negedge clock);
    data_i  = 8'h00;
    valid_i = 1'b1;
    @(posedge clock);
    #1 data_i = 8'hFF;
    fork
      begin
        @(negedge clock);
        check("b2b_latency", {31'd0, tx_o}, 32'd1);
        check_frame("b2b_first", 8'h00, 4);
        check_frame("b2b_second", 8'hFF, 4);
      end
      begin
        @(negedge clock);
        check("b2b_ready_full0", {31'd0, ready_o}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 valid_i = 1'b0;
        @(negedge clock);
        check("b2b_ready_full1", {31'd0, ready_o}, 32'd0);
        check("b2b_busy", {31'd0, busy_o}, 32'd1);
      end
    join
    @(negedge clock);
    check("b2b_busy_end", {31'd0, busy_o}, 32'd0);

    // clamp
    clkdiv_i = 16'd1;
    send(8'h5A);
    @(negedge clock);
    check_frame("clamp_frame", 8'h5A, 4);

    // divider latched at frame start
    clkdiv_i = 16'd8;
    send(8'h33);
    fork
      begin
        @(negedge clock);
        check_frame("latch_div8", 8'h33, 8);
      end
      begin
        repeat (20) @(negedge clock);
        clkdiv_i = 16'd16;
      end
    join
    send(8'h0F);
    @(negedge clock);
    check_frame("latch_div16", 8'h0F, 16);
    clkdiv_i = 16'd4;

    // enable gating
    send(8'h3C);
    fork
      begin
        @(negedge clock);
        check_frame("gate_3c", 8'h3C, 4);
        repeat (20) begin
          @(negedge clock);
          check("gate_hold", {31'd0, tx_o}, 32'd1);
        end
      end
      begin
        send(8'h55);
        @(negedge clock);
        enable_i = 1'b0;
        check("gate_ready", {31'd0, ready_o}, 32'd0);
      end
    join
    check("gate_busy_buffered", {31'd0, busy_o}, 32'd1);
    enable_i = 1'b1;
    check_frame("gate_55", 8'h55, 4);
    @(negedge clock);
    check("gate_busy_end", {31'd0, busy_o}, 32'd0);
    enable_i = 1'b0;
    #1 check("en_drop_ready", {31'd0, ready_o}, 32'd0);
    enable_i = 1'b1;
    #1 check("en_rise_ready", {31'd0, ready_o}, 32'd1);

    // reset during data bit 3, with a byte pending
    send(8'hC3);
    send(8'h99);
    repeat (17) @(negedge clock);
    check("rst_mid_bit3", {31'd0, tx_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd1);
    resetb = 1'b0;
    @(negedge clock);
    check("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    check("rst_mid_ready", {31'd0, ready_o}, 32'd0);
    check("rst_mid_busy0", {31'd0, busy_o}, 32'd0);
    resetb = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_discard_tx", {31'd0, tx_o}, 32'd1);
    end
    check("rst_discard_busy", {31'd0, busy_o}, 32'd0);
    send(8'h81);
    @(negedge clock);
    check_frame("rst_81", 8'h81, 4);
    @(negedge clock);
    check("rst_81_busy_end", {31'd0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
